// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control FSM and the CPU datapath.
// master = control unit (drives control lines), slave = datapath (drives opcode/zero).
interface multicycle_control_unit_if #(
  parameter int OPW = 6,
  parameter int STW = 3
);
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           PCWre;
  logic           InsMemRW;
  logic           IRWre;
  logic [1:0]     RegOut;
  logic           RegWre;
  logic           ALUSrcB;
  logic           ALUM2Reg;
  logic           WrRegDSrc;
  logic [1:0]     PCSrc;
  logic           DataMemRW;
  logic [1:0]     Extsel;
  logic [2:0]     ALUOp;
  logic [STW-1:0] CurState;

  modport master (
    input  opcode, zero,
    output PCWre, InsMemRW, IRWre, RegOut, RegWre, ALUSrcB, ALUM2Reg,
           WrRegDSrc, PCSrc, DataMemRW, Extsel, ALUOp, CurState
  );

  modport slave (
    output opcode, zero,
    input  PCWre, InsMemRW, IRWre, RegOut, RegWre, ALUSrcB, ALUM2Reg,
           WrRegDSrc, PCSrc, DataMemRW, Extsel, ALUOp, CurState
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: decodes the opcode and sequences IF/ID/EXE/MEM/WB,
// driving all datapath control lines combinationally from (state, opcode, zero).
module multicycle_control_unit #(
  parameter int OPW = 6,
  parameter int STW = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_control_unit_if.master   bus
);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(6'b000001);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6'b010000);
  localparam logic [OPW-1:0] OP_AND  = OPW'(6'b010001);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b010010);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(6'b011000);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(6'b100110);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b110000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b110001);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b110100);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b111000);
  localparam logic [OPW-1:0] OP_JR   = OPW'(6'b111001);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(6'b111010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(6'b111111);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_L   = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  state_t state, state_nxt;

  logic is_rtype, is_imm_alu, is_lw, is_sw, is_beq, is_j, is_jr, is_jal, is_halt;
  logic [1:0] reg_out_dec, extsel_dec;
  logic [2:0] alu_op_dec;
  logic       alu_src_b_dec;

  // Opcode decode; these fields depend only on the opcode so they stay
  // stable for every cycle of the instruction.
  always_comb begin
    is_rtype      = 1'b0;
    is_imm_alu    = 1'b0;
    is_lw         = 1'b0;
    is_sw         = 1'b0;
    is_beq        = 1'b0;
    is_j          = 1'b0;
    is_jr         = 1'b0;
    is_jal        = 1'b0;
    is_halt       = 1'b0;
    reg_out_dec   = 2'b00;
    extsel_dec    = 2'b00;
    alu_op_dec    = 3'b000;
    alu_src_b_dec = 1'b0;
    case (bus.opcode)
      OP_ADD:  begin is_rtype = 1'b1; reg_out_dec = 2'b10; alu_op_dec = 3'b000; end
      OP_SUB:  begin is_rtype = 1'b1; reg_out_dec = 2'b10; alu_op_dec = 3'b001; end
      OP_OR:   begin is_rtype = 1'b1; reg_out_dec = 2'b10; alu_op_dec = 3'b010; end
      OP_AND:  begin is_rtype = 1'b1; reg_out_dec = 2'b10; alu_op_dec = 3'b011; end
      OP_SLL:  begin is_rtype = 1'b1; reg_out_dec = 2'b10; alu_op_dec = 3'b100; extsel_dec = 2'b00; end
      OP_SLT:  begin is_rtype = 1'b1; reg_out_dec = 2'b10; alu_op_dec = 3'b101; end
      OP_ADDI: begin
        is_imm_alu = 1'b1; reg_out_dec = 2'b01; alu_op_dec = 3'b000;
        extsel_dec = 2'b10; alu_src_b_dec = 1'b1;
      end
      OP_ORI:  begin
        is_imm_alu = 1'b1; reg_out_dec = 2'b01; alu_op_dec = 3'b010;
        extsel_dec = 2'b01; alu_src_b_dec = 1'b1;
      end
      OP_LW:   begin
        is_lw = 1'b1; reg_out_dec = 2'b01; alu_op_dec = 3'b000;
        extsel_dec = 2'b10; alu_src_b_dec = 1'b1;
      end
      OP_SW:   begin
        is_sw = 1'b1; alu_op_dec = 3'b000;
        extsel_dec = 2'b10; alu_src_b_dec = 1'b1;
      end
      OP_BEQ:  begin is_beq = 1'b1; alu_op_dec = 3'b001; extsel_dec = 2'b10; end
      OP_J:    is_j = 1'b1;
      OP_JR:   is_jr = 1'b1;
      OP_JAL:  begin is_jal = 1'b1; reg_out_dec = 2'b00; end
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IF;
    else        state <= state_nxt;
  end

  logic pc_wre_raw, reg_wre_raw, dmem_wr_raw, ir_wre_raw;

  always_comb begin
    state_nxt     = state;
    pc_wre_raw    = 1'b0;
    reg_wre_raw   = 1'b0;
    dmem_wr_raw   = 1'b0;
    ir_wre_raw    = 1'b0;
    bus.ALUM2Reg  = 1'b0;
    bus.WrRegDSrc = 1'b0;
    bus.PCSrc     = 2'b00;
    case (state)
      S_IF: begin
        ir_wre_raw = 1'b1;
        state_nxt  = S_ID;
      end
      S_ID: begin
        if (is_rtype || is_imm_alu) state_nxt = S_EXE_AL;
        else if (is_beq)            state_nxt = S_EXE_BR;
        else if (is_lw || is_sw)    state_nxt = S_EXE_LS;
        else if (is_halt)           state_nxt = S_ID;
        else begin
          // Jumps and unknown opcodes (nop) retire here.
          state_nxt  = S_IF;
          pc_wre_raw = 1'b1;
          if (is_j || is_jal) bus.PCSrc = 2'b11;
          else if (is_jr)     bus.PCSrc = 2'b10;
          if (is_jal) begin
            reg_wre_raw   = 1'b1;
            bus.WrRegDSrc = 1'b1;
          end
        end
      end
      S_EXE_AL: state_nxt = S_WB_AL;
      S_WB_AL: begin
        state_nxt   = S_IF;
        pc_wre_raw  = 1'b1;
        reg_wre_raw = 1'b1;
      end
      S_EXE_BR: begin
        state_nxt  = S_IF;
        pc_wre_raw = 1'b1;
        bus.PCSrc  = bus.zero ? 2'b01 : 2'b00;
      end
      S_EXE_LS: state_nxt = S_MEM;
      S_MEM: begin
        if (is_lw) state_nxt = S_WB_L;
        else begin
          state_nxt   = S_IF;
          pc_wre_raw  = 1'b1;
          dmem_wr_raw = is_sw;
        end
      end
      S_WB_L: begin
        state_nxt    = S_IF;
        pc_wre_raw   = 1'b1;
        reg_wre_raw  = 1'b1;
        bus.ALUM2Reg = 1'b1;
      end
      default: state_nxt = S_IF;
    endcase
  end

  // Write/load enables are gated by reset so nothing commits while rst_n is low.
  assign bus.PCWre     = pc_wre_raw  & rst_n;
  assign bus.RegWre    = reg_wre_raw & rst_n;
  assign bus.DataMemRW = dmem_wr_raw & rst_n;
  assign bus.IRWre     = ir_wre_raw  & rst_n;
  assign bus.InsMemRW  = 1'b1;
  assign bus.RegOut    = reg_out_dec;
  assign bus.ALUSrcB   = alu_src_b_dec;
  assign bus.Extsel    = extsel_dec;
  assign bus.ALUOp     = alu_op_dec;
  assign bus.CurState  = STW'(state);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class
// through its state sequence and checks control lines cycle by cycle.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  multicycle_control_unit_if #(.OPW(6), .STW(3)) bus ();

  multicycle_control_unit #(.OPW(6), .STW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
    $fatal(1);
  end

  task automatic test_reset;
    rst_n = 1'b0;
    bus.opcode = 6'b000000;
    bus.zero = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.CurState !== 3'b000) begin failures++; $display("FAIL reset_state got=%b exp=000", bus.CurState); end
    checks++;
    if ({bus.IRWre, bus.PCWre, bus.RegWre, bus.DataMemRW} !== 4'b0000) begin
      failures++; $display("FAIL reset_enables got=%b exp=0000", {bus.IRWre, bus.PCWre, bus.RegWre, bus.DataMemRW});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.IRWre !== 1'b1) begin failures++; $display("FAIL reset_release_irwre got=%b exp=1", bus.IRWre); end
    checks++;
    if (bus.InsMemRW !== 1'b1) begin failures++; $display("FAIL reset_insmemrw got=%b exp=1", bus.InsMemRW); end
  endtask

  task automatic test_add;
    logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd6, 3'd7};
    bus.opcode = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.CurState !== exp_st[i]) begin failures++; $display("FAIL add_state[%0d] got=%b exp=%b", i, bus.CurState, exp_st[i]); end
      checks++;
      if (bus.RegWre !== (i == 3)) begin failures++; $display("FAIL add_regwre[%0d] got=%b exp=%b", i, bus.RegWre, (i == 3)); end
      checks++;
      if (bus.PCWre !== (i == 3)) begin failures++; $display("FAIL add_pcwre[%0d] got=%b exp=%b", i, bus.PCWre, (i == 3)); end
      checks++;
      if (bus.IRWre !== (i == 0)) begin failures++; $display("FAIL add_irwre[%0d] got=%b exp=%b", i, bus.IRWre, (i == 0)); end
      if (i >= 2) begin
        checks++;
        if (bus.ALUOp !== 3'b000) begin failures++; $display("FAIL add_aluop[%0d] got=%b exp=000", i, bus.ALUOp); end
      end
      if (i == 3) begin
        checks++;
        if (bus.RegOut !== 2'b10) begin failures++; $display("FAIL add_regout got=%b exp=10", bus.RegOut); end
      end
      @(negedge clk);
    end
    checks++;
    if (bus.CurState !== 3'b000) begin failures++; $display("FAIL add_return got=%b exp=000", bus.CurState); end
  endtask

  task automatic test_lw;
    logic [2:0] exp_st [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    bus.opcode = 6'b110001;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.CurState !== exp_st[i]) begin failures++; $display("FAIL lw_state[%0d] got=%b exp=%b", i, bus.CurState, exp_st[i]); end
      checks++;
      if (bus.ALUSrcB !== 1'b1 || bus.Extsel !== 2'b10) begin
        failures++; $display("FAIL lw_srcb_ext[%0d] got=%b/%b exp=1/10", i, bus.ALUSrcB, bus.Extsel);
      end
      checks++;
      if (bus.DataMemRW !== 1'b0) begin failures++; $display("FAIL lw_dmem[%0d] got=%b exp=0", i, bus.DataMemRW); end
      checks++;
      if ({bus.RegWre, bus.ALUM2Reg, bus.PCWre} !== ((i == 4) ? 3'b111 : 3'b000)) begin
        failures++; $display("FAIL lw_wb[%0d] got=%b exp=%b", i, {bus.RegWre, bus.ALUM2Reg, bus.PCWre}, ((i == 4) ? 3'b111 : 3'b000));
      end
      if (i == 4) begin
        checks++;
        if (bus.RegOut !== 2'b01) begin failures++; $display("FAIL lw_regout got=%b exp=01", bus.RegOut); end
      end
      @(negedge clk);
    end
    checks++;
    if (bus.CurState !== 3'b000) begin failures++; $display("FAIL lw_return got=%b exp=000", bus.CurState); end
  endtask

  task automatic test_beq(input logic zv);
    logic [2:0] exp_st [3] = '{3'd0, 3'd1, 3'd5};
    logic [1:0] exp_pcsrc;
    bus.opcode = 6'b110100;
    for (int i = 0; i < 3; i++) begin
      // zero carries the opposite value outside EXE_BR to show it is ignored there.
      bus.zero = (i == 2) ? zv : ~zv;
      #1;
      exp_pcsrc = (i == 2 && zv) ? 2'b01 : 2'b00;
      checks++;
      if (bus.CurState !== exp_st[i]) begin failures++; $display("FAIL beq%0d_state[%0d] got=%b exp=%b", zv, i, bus.CurState, exp_st[i]); end
      checks++;
      if (bus.PCSrc !== exp_pcsrc) begin failures++; $display("FAIL beq%0d_pcsrc[%0d] got=%b exp=%b", zv, i, bus.PCSrc, exp_pcsrc); end
      checks++;
      if (bus.PCWre !== (i == 2)) begin failures++; $display("FAIL beq%0d_pcwre[%0d] got=%b exp=%b", zv, i, bus.PCWre, (i == 2)); end
      if (i == 2) begin
        checks++;
        if (bus.ALUOp !== 3'b001 || bus.Extsel !== 2'b10) begin
          failures++; $display("FAIL beq%0d_aluop_ext got=%b/%b exp=001/10", zv, bus.ALUOp, bus.Extsel);
        end
      end
      @(negedge clk);
    end
    bus.zero = 1'b0;
    checks++;
    if (bus.CurState !== 3'b000) begin failures++; $display("FAIL beq%0d_return got=%b exp=000", zv, bus.CurState); end
  endtask

  task automatic test_jal;
    bus.opcode = 6'b111010;
    #1;
    checks++;
    if (bus.CurState !== 3'b000 || bus.RegWre !== 1'b0) begin
      failures++; $display("FAIL jal_if got=%b/%b exp=000/0", bus.CurState, bus.RegWre);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.CurState !== 3'b001) begin failures++; $display("FAIL jal_state got=%b exp=001", bus.CurState); end
    checks++;
    if ({bus.PCSrc, bus.RegWre, bus.RegOut, bus.WrRegDSrc, bus.PCWre} !== 7'b11_1_00_1_1) begin
      failures++; $display("FAIL jal_ctrl got=%b exp=1110011", {bus.PCSrc, bus.RegWre, bus.RegOut, bus.WrRegDSrc, bus.PCWre});
    end
    @(negedge clk);
    checks++;
    if (bus.CurState !== 3'b000) begin failures++; $display("FAIL jal_return got=%b exp=000", bus.CurState); end
  endtask

  task automatic test_jump;
    logic [5:0] ops [2] = '{6'b111000, 6'b111001};
    logic [1:0] exp_src [2] = '{2'b11, 2'b10};
    for (int k = 0; k < 2; k++) begin
      bus.opcode = ops[k];
      @(negedge clk);
      #1;
      checks++;
      if ({bus.CurState, bus.PCSrc, bus.PCWre, bus.RegWre} !== {3'b001, exp_src[k], 1'b1, 1'b0}) begin
        failures++; $display("FAIL jump%0d_id got=%b exp=%b", k, {bus.CurState, bus.PCSrc, bus.PCWre, bus.RegWre}, {3'b001, exp_src[k], 1'b1, 1'b0});
      end
      @(negedge clk);
      checks++;
      if (bus.CurState !== 3'b000) begin failures++; $display("FAIL jump%0d_return got=%b exp=000", k, bus.CurState); end
    end
  endtask

  task automatic test_nop;
    bus.opcode = 6'b101010;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.CurState, bus.PCSrc, bus.PCWre, bus.RegWre, bus.DataMemRW} !== 8'b001_00_1_0_0) begin
      failures++; $display("FAIL nop_id got=%b exp=00100100", {bus.CurState, bus.PCSrc, bus.PCWre, bus.RegWre, bus.DataMemRW});
    end
    @(negedge clk);
    checks++;
    if (bus.CurState !== 3'b000) begin failures++; $display("FAIL nop_return got=%b exp=000", bus.CurState); end
  endtask

  task automatic test_halt;
    bus.opcode = 6'b111111;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({bus.CurState, bus.PCWre, bus.RegWre, bus.DataMemRW, bus.IRWre} !== 7'b001_0000) begin
        failures++; $display("FAIL halt_hold[%0d] got=%b exp=0010000", i, {bus.CurState, bus.PCWre, bus.RegWre, bus.DataMemRW, bus.IRWre});
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.CurState !== 3'b000) begin failures++; $display("FAIL halt_reset_exit got=%b exp=000", bus.CurState); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_sw;
    bus.opcode = 6'b110000;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus.CurState, bus.DataMemRW, bus.PCWre} !== 5'b011_1_1) begin
      failures++; $display("FAIL sw_mem got=%b exp=01111", {bus.CurState, bus.DataMemRW, bus.PCWre});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.CurState !== 3'b000) begin failures++; $display("FAIL sw_async_state got=%b exp=000", bus.CurState); end
    checks++;
    if ({bus.DataMemRW, bus.PCWre, bus.RegWre, bus.IRWre} !== 4'b0000) begin
      failures++; $display("FAIL sw_async_enables got=%b exp=0000", {bus.DataMemRW, bus.PCWre, bus.RegWre, bus.IRWre});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.CurState, bus.DataMemRW, bus.IRWre} !== 5'b000_0_0) begin
      failures++; $display("FAIL sw_reset_hold got=%b exp=00000", {bus.CurState, bus.DataMemRW, bus.IRWre});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.IRWre !== 1'b1) begin failures++; $display("FAIL sw_release_irwre got=%b exp=1", bus.IRWre); end
    @(negedge clk);
    checks++;
    if (bus.CurState !== 3'b001) begin failures++; $display("FAIL sw_release_leave_if got=%b exp=001", bus.CurState); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_lw;
    test_beq(1'b1);
    test_beq(1'b0);
    test_jal;
    test_jump;
    test_nop;
    test_halt;
    test_reset_mid_sw;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Control FSM for the MultiCycle_CPU datapath: decodes the 6-bit opcode and sequences IF/ID/EXE/MEM/WB.
- Drives every datapath control line (PCWre, InsMemRW, IRWre, RegOut, RegWre, ALUSrcB, ALUM2Reg, WrRegDSrc, PCSrc, DataMemRW, Extsel, ALUOp).
- Consumes the ALU zero flag.
- Sits between instruction register and datapath; replaces bench-driven control stimulus.

Parameters:
- OPW, 6, opcode width
- STW, 3, state encoding width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPW  IR[31:26]
- zero  in  1  ALU zero flag, valid during EXE
- PCWre  out  1  PC load enable
- InsMemRW  out  1  instruction memory read (1 = read)
- IRWre  out  1  instruction register load enable
- RegOut  out  2  write-reg select: 00 = $31, 01 = rt, 10 = rd
- RegWre  out  1  register file write enable
- ALUSrcB  out  1  0 = ReadData2, 1 = extended immediate
- ALUM2Reg  out  1  0 = ALU result, 1 = memory data
- WrRegDSrc  out  1  0 = ALUM2Reg path, 1 = PC+4 (jal)
- PCSrc  out  2  00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs, 11 = jump target
- DataMemRW  out  1  1 = write data memory
- Extsel  out  2  00 = zero-ext sa, 01 = zero-ext imm, 10 = sign-ext imm
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 and, 100 sll, 101 slt (signed)
- CurState  out  STW  debug state

Behaviour:
- Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111. Any other opcode is treated as nop: IF→ID→IF with PCWre=1, PCSrc=00 in ID.
- States: sIF 000, sID 001, sEXE_LS 010, sMEM 011, sWB_L 100, sEXE_BR 101, sEXE_AL 110, sWB_AL 111. Halt holds in sID with all enables low.
- Transitions:
  - sIF→sID always.
  - sID→sEXE_AL for add/sub/addi/or/and/ori/sll/slt.
  - sID→sEXE_BR for beq.
  - sID→sEXE_LS for sw/lw.
  - sID→sIF for j/jr/jal.
  - sID holds for halt.
  - sEXE_AL→sWB_AL→sIF.
  - sEXE_BR→sIF.
  - sEXE_LS→sMEM.
  - sMEM→sWB_L for lw; sMEM→sIF for sw.
  - sWB_L→sIF.
- Outputs are combinational from (state, opcode, zero); state is the only register.
- Cycle counts: R/I-type 4, beq 3, sw 4, lw 5, j/jr/jal 2.
- PCWre=1 only in the final cycle of an instruction: sID for j/jr/jal, sEXE_BR, sWB_AL, sMEM for sw, sWB_L. This gives exactly one PC update per instruction.
- IRWre=1 only in sIF. InsMemRW=1 in all states.
- PCSrc:
  - sEXE_BR: 01 if zero=1, else 00.
  - sID: j/jal 11, jr 10.
  - All other cycles: 00.
- RegWre=1 only in: sWB_AL, sWB_L, and sID for jal.
- RegOut: rd (10) for add/sub/or/and/sll/slt; rt (01) for addi/ori/lw; 00 for jal.
- DataMemRW=1 only in sMEM with sw.
- ALUM2Reg=1 in sWB_L.
- WrRegDSrc=1 in sID for jal.
- ALUSrcB=1 for addi/ori/lw/sw.
- Extsel: 00 sll; 01 ori; 10 addi/lw/sw/beq.
- ALUOp: beq uses sub; lw/sw/addi use add.
- Decode-based outputs (RegOut, ALUSrcB, Extsel, ALUOp) are held stable across EXE/MEM/WB of the same instruction.
- Reset (async, any state): state→sIF immediately; PCWre, RegWre, DataMemRW, IRWre forced 0 while rst_n=0. Reset mid-instruction abandons it with no register or memory write after assertion.
- After rst_n rises, the first rising edge leaves sIF; IRWre is high during that first cycle.
- zero is ignored outside sEXE_BR.

Test Plan:
- Reset: rst_n=0 mid-sMEM of sw → CurState=000 and DataMemRW=0 with no clock edge; release → IRWre=1 in first cycle.
- add (000000): states 000,001,110,111,000; RegWre=1 and RegOut=10 only in 111; PCWre=1 only in 111; ALUOp=000.
- lw (110001): 000,001,010,011,100; ALUSrcB=1, Extsel=10 throughout; RegWre=1, ALUM2Reg=1, RegOut=01 in 100; DataMemRW never 1.
- beq (110100): with zero=1 → PCSrc=01, PCWre=1 in state 101; repeat with zero=0 → PCSrc=00; ALUOp=001.
- jal (111010): 2 cycles; in sID PCSrc=11, RegWre=1, RegOut=00, WrRegDSrc=1, PCWre=1.
- halt (111111): stays in 001 for ≥10 cycles with PCWre=RegWre=DataMemRW=0. Undefined opcode 101010 completes as nop in 2 cycles.
